// File: rtl/alu_bist_pkg.sv
// Shared constants and types for the ALU BIST engine: opcode encodings, FSM states,
// LFSR and MISR tap definitions.
package alu_bist_pkg;

  // Pattern register width and pattern index width
  localparam int unsigned LFSR_W = 10;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned MISR_W = 4;

  // ALU opcodes carried in pat_op
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // x^10 + x^7 + 1, Fibonacci form: feedback = lfsr[9] ^ lfsr[6]
  localparam int unsigned LFSR_TAP_HI = 9;
  localparam int unsigned LFSR_TAP_LO = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 10'h001;

  // x^4 + x^3 + 1: the shifted-out bit folds back into bits 3 and 0
  localparam logic [MISR_W-1:0] MISR_TAPS = 4'b1001;

endpackage

// File: rtl/alu_bist_engine_if.sv
// Bus between the BIST engine and its environment: stimulus towards the ALU, response
// back from it, plus run control and status.
interface alu_bist_engine_if
  import alu_bist_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned OP_W   = 2
) ();

  logic              start;
  logic [DATA_W-1:0] alu_c;
  logic [DATA_W-1:0] pat_a;
  logic [DATA_W-1:0] pat_b;
  logic [OP_W-1:0]   pat_op;
  logic              busy;
  logic              done;
  logic              pass;
  logic [DATA_W-1:0] signature;
  logic [IDX_W-1:0]  pattern_idx;

  // Environment side: issues start, returns the ALU result, observes status
  modport master (
    output start, alu_c,
    input  pat_a, pat_b, pat_op, busy, done, pass, signature, pattern_idx
  );

  // Engine side
  modport slave (
    input  start, alu_c,
    output pat_a, pat_b, pat_op, busy, done, pass, signature, pattern_idx
  );

endinterface

// File: rtl/bist_lfsr.sv
// Pattern register: 10-bit Fibonacci LFSR that can be loaded with a seed or stepped.
// Clears to zero on reset so the driven pattern is all-zero while idle.
module bist_lfsr
  import alu_bist_pkg::*;
#(
  parameter int unsigned       WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0]  SEED  = LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Next-state: load wins over step, otherwise hold
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (step) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
    end
  end

  // Pattern register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/alu_bist_engine.sv
// BIST source/sink for the 4-bit ALU. Drives LFSR patterns as {A,B,Op}, folds each ALU
// result into a MISR and compares the final signature with a golden value.
module alu_bist_engine
  import alu_bist_pkg::*;
#(
  parameter int unsigned        DATA_W      = 4,
  parameter int unsigned        OP_W        = 2,
  parameter int unsigned        PATTERN_CNT = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED   = LFSR_SEED_DEFAULT,
  parameter logic [DATA_W-1:0]  GOLDEN_SIG  = '0
) (
  input logic              clk,
  input logic              rst,
  alu_bist_engine_if.slave bus
);

  // An all-zero seed would lock the LFSR, so substitute the minimal nonzero state
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 10'h001 : LFSR_SEED;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PATTERN_CNT - 1);

  bist_state_e       state_q, state_d;
  logic [DATA_W-1:0] sig_q, sig_d, sig_next;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pass_q, pass_d;
  logic              lfsr_load;
  logic              lfsr_step_en;
  logic [LFSR_W-1:0] lfsr_state;

  bist_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step_en),
    .state (lfsr_state)
  );

  // MISR update for the result of the pattern currently on the bus
  always_comb begin
    sig_next = {sig_q[DATA_W-2:0], 1'b0}
             ^ (DATA_W'(MISR_TAPS) & {DATA_W{sig_q[DATA_W-1]}})
             ^ bus.alu_c;
  end

  // FSM next-state, signature/counter/pass updates and LFSR control
  always_comb begin
    state_d      = state_q;
    sig_d        = sig_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          sig_d     = '0;
          idx_d     = '0;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
        end
      end
      ST_RUN: begin
        sig_d = sig_next;
        if (idx_q == LAST_IDX) begin
          // Last result absorbed; freeze the pattern and latch the verdict
          state_d = ST_DONE;
          pass_d  = (sig_next == GOLDEN_SIG);
        end else begin
          idx_d        = idx_q + 1'b1;
          lfsr_step_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, signature, pattern index and verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.pat_op      = lfsr_state[OP_W-1:0];
  assign bus.pat_b       = lfsr_state[OP_W +: DATA_W];
  assign bus.pat_a       = lfsr_state[OP_W+DATA_W +: DATA_W];
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.pass        = pass_q;
  assign bus.signature   = sig_q;
  assign bus.pattern_idx = idx_q;

endmodule
